hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. It sequences the IF/ID register and the PC by driving the PC write-enable, the IF/ID write-enable and IF/ID flush, and the ID/EX bubble. It resolves load-use hazards, the extra stalls needed because branches compare operands in ID, taken-branch/jump flushes, and instruction-memory wait cycles. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Drives the PC / IF-ID enables, the IF-ID flush and the ID-EX bubble.
// It resolves load-use hazards, branch-in-ID operand hazards, taken-branch
// and jump flushes, and instruction-memory wait cycles. It also keeps
// saturating stall and flush counters for performance debug.
//
// Handshake: none. All outputs are combinational from the state register
// and the current inputs. State and counters advance on the rising clk edge.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stall_st,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // STALL is the second cycle of a load-feeding-a-branch stall.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_dep_ex;
  logic w_dep_mem;
  logic w_need2;
  logic w_need1;
  logic w_redirect;
  logic w_stall_inc;
  logic w_flush_inc;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;

  // Dependence of the ID instruction on the EX and MEM destinations.
  // Register 0 is hardwired to zero, so it never creates a hazard.
  always_comb begin
    w_dep_ex   = (ex_rd != 5'd0) &&
                 ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    w_dep_mem  = (mem_rd != 5'd0) &&
                 ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));
    // Load in EX feeding a branch: the data only exists after MEM, two stalls.
    w_need2    = id_is_branch && ex_mem_read && w_dep_ex;
    // Single-cycle stalls: plain load-use, ALU result into a branch compare,
    // and a load still in MEM feeding a branch compare.
    w_need1    = (ex_mem_read && w_dep_ex) ||
                 (id_is_branch && ex_reg_write && w_dep_ex) ||
                 (id_is_branch && mem_mem_read && w_dep_mem);
    w_redirect = branch_taken || jump;
  end

  // Prioritised decision: imem wait, STALL state, hazards, redirect, pass.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;

    if (!imem_ready) begin
      // Fetch is waiting: freeze the front end, keep the branch in ID.
      // The back end keeps draining, so a pending STALL still retires.
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_state_nxt   = ST_RUN;
    end else if (r_state == ST_STALL) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_state_nxt   = ST_RUN;
      w_stall_inc   = 1'b1;
    end else if (w_need2) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_state_nxt   = ST_STALL;
      w_stall_inc   = 1'b1;
    end else if (w_need1) begin
      // Hazard beats a taken branch: its compare operands are stale.
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_stall_inc   = 1'b1;
    end else if (w_redirect) begin
      w_ifid_flush  = 1'b1;
      w_flush_inc   = 1'b1;
    end

    // While reset is held the pipeline front end is frozen.
    if (rst) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b1;
    end
  end

  // State register, asynchronously returned to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stall cycle counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (cnt_clr) begin
      r_stall_cycles <= '0;
    end else if (w_stall_inc && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  // Flush event counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_count <= '0;
    end else if (cnt_clr) begin
      r_flush_count <= '0;
    end else if (w_flush_inc && !(&r_flush_count)) begin
      r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  // Output drive.
  always_comb begin
    pc_write     = w_pc_write;
    ifid_write   = w_ifid_write;
    ifid_flush   = w_ifid_flush;
    idex_bubble  = w_idex_bubble;
    stall_st     = r_state;
    stall_cycles = r_stall_cycles;
    flush_count  = r_flush_count;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios for hazard_ctrl with an output
// scoreboard. Each cycle's expected {pc_write, ifid_write, ifid_flush,
// idex_bubble, stall_st} is pushed when the stimulus is driven and popped
// on the following falling edge.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, stall_st}
  localparam logic [4:0] M_STALL_RUN = 5'b00010;
  localparam logic [4:0] M_STALL_STL = 5'b00011;
  localparam logic [4:0] M_FLUSH     = 5'b11100;
  localparam logic [4:0] M_PASS      = 5'b11000;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_ready;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             branch_taken;
  logic             jump;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_mem_read;
  logic [4:0]       mem_rd;
  logic             cnt_clr;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             stall_st;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  logic [4:0] exp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  string      cur_test = "none";
  int         exp_stall = 0;
  int         exp_flush = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .branch_taken(branch_taken), .jump(jump),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall_st(stall_st),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard: compare the pipeline control outputs mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      logic [4:0] o;
      e = exp_q.pop_front();
      o = {pc_write, ifid_write, ifid_flush, idex_bubble, stall_st};
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s outputs: got %b expected %b (pc,ifid_w,flush,bubble,st)",
                 cur_test, o, e);
      end
    end
  end

  // Driver tasks
  task automatic clear_inputs();
    imem_ready   = 1'b1;
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    id_uses_rt   = 1'b0;
    id_is_branch = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    ex_reg_write = 1'b0;
    ex_mem_read  = 1'b0;
    ex_rd        = 5'd0;
    mem_mem_read = 1'b0;
    mem_rd       = 5'd0;
    cnt_clr      = 1'b0;
  endtask

  // Inputs are already applied; push the expected mode, let the scoreboard
  // sample on the falling edge, then return just after the rising edge.
  task automatic step(input logic [4:0] exp_mode);
    exp_q.push_back(exp_mode);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, stall_st} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00010",
               {pc_write, ifid_write, ifid_flush, idex_bubble, stall_st});
    end
    n_cmp++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_load_use();
    cur_test = "load_use";
    clear_inputs();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    step(M_STALL_RUN);
    exp_stall++;
    clear_inputs();
    step(M_PASS);
    n_cmp++;
    if (stall_cycles !== CNT_W'(exp_stall)) begin
      n_fail++;
      $display("FAIL load_use_cnt: got %0d expected %0d", stall_cycles, exp_stall);
    end
    // ALU result in EX with a normal consumer is forwarded: no stall.
    ex_reg_write = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    step(M_PASS);
    // rt matches but is not a source: no stall.
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b0;
    step(M_PASS);
  endtask

  task automatic test_branch_hazards();
    cur_test = "load_branch";
    clear_inputs();
    id_is_branch = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    step(M_STALL_RUN);
    clear_inputs();
    step(M_STALL_STL);
    step(M_PASS);
    exp_stall += 2;
    n_cmp++;
    if (stall_cycles !== CNT_W'(exp_stall)) begin
      n_fail++;
      $display("FAIL load_branch_cnt: got %0d expected %0d", stall_cycles, exp_stall);
    end
    cur_test = "alu_branch";
    id_is_branch = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    step(M_STALL_RUN);
    exp_stall++;
    clear_inputs();
    step(M_PASS);
    cur_test = "mem_load_branch";
    id_is_branch = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd7;
    id_rt = 5'd7; id_uses_rt = 1'b1;
    step(M_STALL_RUN);
    exp_stall++;
    clear_inputs();
    step(M_PASS);
    n_cmp++;
    if (stall_cycles !== CNT_W'(exp_stall)) begin
      n_fail++;
      $display("FAIL branch_hazard_cnt: got %0d expected %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_flush();
    cur_test = "flush";
    clear_inputs();
    branch_taken = 1'b1;
    step(M_FLUSH);
    exp_flush++;
    // Register 0 never hazards, even with a load in EX.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_is_branch = 1'b1;
    step(M_FLUSH);
    exp_flush++;
    clear_inputs();
    jump = 1'b1;
    step(M_FLUSH);
    exp_flush++;
    clear_inputs();
    step(M_PASS);
    n_cmp++;
    if (flush_count !== CNT_W'(exp_flush)) begin
      n_fail++;
      $display("FAIL flush_cnt: got %0d expected %0d", flush_count, exp_flush);
    end
  endtask

  task automatic test_hazard_vs_flush();
    cur_test = "hazard_vs_flush";
    clear_inputs();
    id_is_branch = 1'b1; branch_taken = 1'b1; ex_reg_write = 1'b1;
    ex_rd = 5'd3; id_rs = 5'd3;
    step(M_STALL_RUN);
    exp_stall++;
    n_cmp++;
    if (flush_count !== CNT_W'(exp_flush)) begin
      n_fail++;
      $display("FAIL hazard_vs_flush_cnt: got %0d expected %0d", flush_count, exp_flush);
    end
    ex_reg_write = 1'b0; ex_rd = 5'd0;
    step(M_FLUSH);
    exp_flush++;
    clear_inputs();
    step(M_PASS);
    n_cmp++;
    if (flush_count !== CNT_W'(exp_flush) || stall_cycles !== CNT_W'(exp_stall)) begin
      n_fail++;
      $display("FAIL hazard_vs_flush_cnts: got %0d/%0d expected %0d/%0d",
               stall_cycles, flush_count, exp_stall, exp_flush);
    end
  endtask

  task automatic test_imem_wait();
    int n;
    cur_test = "imem_wait";
    clear_inputs();
    n = $urandom_range(3, 3);
    imem_ready = 1'b0; jump = 1'b1;
    for (int i = 0; i < n; i++) step(M_STALL_RUN);
    n_cmp++;
    if (flush_count !== CNT_W'(exp_flush) || stall_cycles !== CNT_W'(exp_stall)) begin
      n_fail++;
      $display("FAIL imem_wait_cnts: got %0d/%0d expected %0d/%0d",
               stall_cycles, flush_count, exp_stall, exp_flush);
    end
    imem_ready = 1'b1;
    step(M_FLUSH);
    exp_flush++;
    // Fetch wait during STALL: state still returns to RUN, not counted.
    cur_test = "imem_wait_in_stall";
    clear_inputs();
    id_is_branch = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs = 5'd12;
    step(M_STALL_RUN);
    exp_stall++;
    clear_inputs();
    imem_ready = 1'b0;
    step(M_STALL_STL);
    imem_ready = 1'b1;
    step(M_PASS);
    n_cmp++;
    if (stall_cycles !== CNT_W'(exp_stall)) begin
      n_fail++;
      $display("FAIL imem_wait_in_stall_cnt: got %0d expected %0d", stall_cycles, exp_stall);
    end
  endtask

  task automatic test_saturation();
    cur_test = "saturation";
    clear_inputs();
    cnt_clr = 1'b1;
    step(M_PASS);
    cnt_clr = 1'b0;
    n_cmp++;
    if (flush_count !== '0 || stall_cycles !== '0) begin
      n_fail++;
      $display("FAIL cnt_clr: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
    jump = 1'b1;
    for (int i = 0; i < 65535; i++) step(M_FLUSH);
    n_cmp++;
    if (flush_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL flush_full: got %h expected ffff", flush_count);
    end
    step(M_FLUSH);
    n_cmp++;
    if (flush_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL flush_saturate: got %h expected ffff", flush_count);
    end
    cnt_clr = 1'b1;
    step(M_FLUSH);
    n_cmp++;
    if (flush_count !== '0) begin
      n_fail++;
      $display("FAIL clr_beats_inc: got %h expected 0000", flush_count);
    end
    clear_inputs();
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_async_reset();
    cur_test = "async_reset";
    clear_inputs();
    id_is_branch = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
    step(M_STALL_RUN);
    clear_inputs();
    // Now in STALL with stall_cycles=1; pulse reset mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (stall_st !== 1'b0 || stall_cycles !== '0 || flush_count !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%b cnt=%0d/%0d expected st=0 cnt=0/0",
               stall_st, stall_cycles, flush_count);
    end
    n_cmp++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble} !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b expected 0001",
               {pc_write, ifid_write, ifid_flush, idex_bubble});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(M_PASS);
  endtask

  task automatic test_back_to_back();
    cur_test = "back_to_back";
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd2; id_rt = 5'd2; id_uses_rt = 1'b1;
    step(M_STALL_RUN);
    clear_inputs();
    jump = 1'b1;
    step(M_FLUSH);
    clear_inputs();
    id_is_branch = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd6; id_rs = 5'd6;
    branch_taken = 1'b1;
    step(M_STALL_RUN);
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    step(M_STALL_STL);
    step(M_FLUSH);
    clear_inputs();
    step(M_PASS);
    n_cmp++;
    if (stall_cycles !== CNT_W'(3) || flush_count !== CNT_W'(2)) begin
      n_fail++;
      $display("FAIL back_to_back_cnts: got %0d/%0d expected 3/2", stall_cycles, flush_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_hazards();
    test_flush();
    test_hazard_vs_flush();
    test_imem_wait();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
